// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared constants and types for the instruction fetch stage
package inst_fetch_pkg;

    localparam logic [5:0]  OP_J             = 6'b000010;
    localparam logic [31:0] NOP_INST         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{pc: 32'h0, pc4: 32'h0, inst: NOP_INST, valid: 1'b0};

    function automatic logic is_jump(input logic [31:0] inst);
        return inst[31:26] == OP_J;
    endfunction

endpackage

// File: rtl/inst_fetch_next_pc_sel.sv
// rtl/inst_fetch_next_pc_sel.sv - combinational next-PC selection and jump target
module next_pc_sel
    import inst_fetch_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] imem_inst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc4,
    output logic [31:0] jump_target,
    output logic [31:0] next_pc
);

    assign pc4         = pc + 32'd4;
    assign jump_target = {pc4[31:28], imem_inst[25:0], 2'b00};

    // Redirect beats stall so a resolved branch is never lost behind a hazard hold.
    always_comb begin
        next_pc = pc4;
        if (br_taken) begin
            next_pc = {br_target[31:2], 2'b00};
        end else if (stall) begin
            next_pc = pc;
        end else if (is_jump(imem_inst)) begin
            next_pc = jump_target;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC register, IF/ID pipeline register and misaligned-target flag
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [31:0] if_inst,
    output logic        if_valid,
    output logic        misalign
);

    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] next_pc;
    ifid_t       ifid;
    ifid_t       ifid_next;

    next_pc_sel u_next_pc_sel (
        .pc          (pc),
        .imem_inst   (imem_inst),
        .stall       (stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc4         (pc4),
        .jump_target (jump_target),
        .next_pc     (next_pc)
    );

    always_comb begin
        ifid_next = '{pc: pc, pc4: pc4, inst: imem_inst, valid: 1'b1};
        if (br_taken || flush) begin
            ifid_next = IFID_BUBBLE;
        end else if (stall) begin
            ifid_next = ifid;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= {RESET_PC[31:2], 2'b00};
            ifid     <= IFID_BUBBLE;
            misalign <= 1'b0;
        end else begin
            pc   <= next_pc;
            ifid <= ifid_next;
            if (br_taken && (br_target[1:0] != 2'b00)) begin
                misalign <= 1'b1;
            end
        end
    end

    assign imem_addr = pc;
    assign if_pc     = ifid.pc;
    assign if_pc4    = ifid.pc4;
    assign if_inst   = ifid.inst;
    assign if_valid  = ifid.valid;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        flush;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [31:0] if_inst;
    logic        if_valid;
    logic        misalign;

    logic [31:0] mem [0:63];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    assign imem_inst = mem[imem_addr[7:2]];

    inst_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .flush     (flush),
        .br_taken  (br_taken),
        .br_target (br_target),
        .imem_addr (imem_addr),
        .imem_inst (imem_inst),
        .if_pc     (if_pc),
        .if_pc4    (if_pc4),
        .if_inst   (if_inst),
        .if_valid  (if_valid),
        .misalign  (misalign)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i);
        mem[0] = 32'h0800_0004;
        mem[8] = 32'h0800_0010;
        rst = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; br_target = 32'h0;

        #2;
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, if_valid}, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_mis", {31'b0, misalign}, 32'h0);

        step();
        rst = 1'b0;
        step();
        check("rel_inst", if_inst, 32'h0800_0004);
        check("rel_pc", if_pc, 32'h0);
        check("rel_pc4", if_pc4, 32'h4);
        check("rel_valid", {31'b0, if_valid}, 32'h1);
        check("rel_jaddr", imem_addr, 32'h10);

        step();
        check("seq_addr", imem_addr, 32'h14);
        check("seq_pc", if_pc, 32'h10);
        check("seq_inst", if_inst, 32'h2000_0004);

        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            check("stall_addr", imem_addr, 32'h14);
            check("stall_pc", if_pc, 32'h10);
            check("stall_inst", if_inst, 32'h2000_0004);
        end
        stall = 1'b0;
        step();
        check("unstall_pc", if_pc, 32'h14);
        check("unstall_inst", if_inst, 32'h2000_0005);
        check("unstall_addr", imem_addr, 32'h18);

        stall = 1'b1; flush = 1'b1;
        step();
        check("stfl_addr", imem_addr, 32'h18);
        check("stfl_valid", {31'b0, if_valid}, 32'h0);
        check("stfl_pc", if_pc, 32'h0);
        stall = 1'b0; flush = 1'b0;
        step();
        check("stfl_rel_pc", if_pc, 32'h18);
        check("stfl_rel_addr", imem_addr, 32'h1C);

        stall = 1'b1; br_taken = 1'b1; br_target = 32'h3C;
        step();
        check("stbr_addr", imem_addr, 32'h3C);
        check("stbr_valid", {31'b0, if_valid}, 32'h0);
        check("stbr_mis", {31'b0, misalign}, 32'h0);

        stall = 1'b0; br_taken = 1'b0; flush = 1'b1;
        step();
        check("flush_addr", imem_addr, 32'h40);
        check("flush_valid", {31'b0, if_valid}, 32'h0);
        flush = 1'b0;

        br_taken = 1'b1; br_target = 32'h3E;
        step();
        check("mis_addr", imem_addr, 32'h3C);
        check("mis_set", {31'b0, misalign}, 32'h1);
        br_target = 32'h20;
        step();
        check("mis_addr2", imem_addr, 32'h20);
        check("mis_sticky", {31'b0, misalign}, 32'h1);

        br_target = 32'hFFFF_FFFC;
        step();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        br_taken = 1'b0;
        step();
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_pc", if_pc, 32'hFFFF_FFFC);
        check("wrap_pc4", if_pc4, 32'h0);
        check("wrap_valid", {31'b0, if_valid}, 32'h1);

        br_taken = 1'b1; br_target = 32'hF000_0020;
        step();
        check("hi_addr", imem_addr, 32'hF000_0020);
        br_taken = 1'b0;
        step();
        check("hij_addr", imem_addr, 32'hF000_0040);
        check("hij_inst", if_inst, 32'h0800_0010);
        check("hij_pc", if_pc, 32'hF000_0020);
        check("hij_mis", {31'b0, misalign}, 32'h1);

        stall = 1'b1;
        step();
        #2;
        rst = 1'b1;
        #1;
        check("arst_addr", imem_addr, 32'h0);
        check("arst_valid", {31'b0, if_valid}, 32'h0);
        check("arst_inst", if_inst, 32'h0);
        check("arst_pc4", if_pc4, 32'h0);
        check("arst_mis", {31'b0, misalign}, 32'h0);
        #1;
        rst = 1'b0; stall = 1'b0;
        step();
        check("arel_inst", if_inst, 32'h0800_0004);
        check("arel_pc", if_pc, 32'h0);
        check("arel_addr", imem_addr, 32'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
